// File: rtl/io_pkg.sv
// Shared I/O widths and defaults for the switch input path into the LSU.
// The LSU and the debouncer both size their switch buses from here.
package io_pkg;

    localparam int SW_WIDTH       = 18;
    localparam int IO_WORD_W      = 32;
    localparam int DEB_CYCLES_DEF = 500000;

endpackage

// File: rtl/sw_debounce_bit.sv
// Single switch bit: 2-flop synchronizer followed by a stability counter FSM.
// o_accept is high in the cycle before o_stable toggles.
//
//   state       | meaning
//   ------------+--------------------------------------------------------
//   DB_STABLE   | sync2 matches the accepted level, cnt held at 0
//   DB_COUNTING | sync2 differs from the accepted level, cnt = run length
module sw_debounce_bit
    import io_pkg::*;
#(
    parameter int DEB_CYCLES = DEB_CYCLES_DEF
) (
    input  logic i_clk,
    input  logic i_reset_n,
    input  logic i_raw,
    output logic o_stable,
    output logic o_accept
);

    localparam int                 CNT_W    = $clog2(DEB_CYCLES + 1);
    localparam logic [CNT_W-1:0]   CNT_LAST = CNT_W'(DEB_CYCLES - 1);

    typedef enum logic {
        DB_STABLE   = 1'b0,
        DB_COUNTING = 1'b1
    } db_state_e;

    db_state_e        state, state_nxt;
    logic [CNT_W-1:0] cnt, cnt_nxt;
    logic             sync1, sync2;
    logic             stable, stable_nxt;

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            sync1  <= 1'b0;
            sync2  <= 1'b0;
            stable <= 1'b0;
            cnt    <= '0;
            state  <= DB_STABLE;
        end else begin
            sync1  <= i_raw;
            sync2  <= sync1;
            stable <= stable_nxt;
            cnt    <= cnt_nxt;
            state  <= state_nxt;
        end
    end

    always_comb begin
        state_nxt  = state;
        cnt_nxt    = cnt;
        stable_nxt = stable;
        o_accept   = 1'b0;
        case (state)
            DB_STABLE: begin
                cnt_nxt = '0;
                if (sync2 != stable) begin
                    // A one-cycle window means the first mismatch is already enough.
                    if (DEB_CYCLES == 1) begin
                        stable_nxt = sync2;
                        o_accept   = 1'b1;
                    end else begin
                        state_nxt = DB_COUNTING;
                        cnt_nxt   = CNT_W'(1);
                    end
                end
            end
            DB_COUNTING: begin
                if (sync2 == stable) begin
                    state_nxt = DB_STABLE;
                    cnt_nxt   = '0;
                end else if (cnt == CNT_LAST) begin
                    stable_nxt = sync2;
                    o_accept   = 1'b1;
                    state_nxt  = DB_STABLE;
                    cnt_nxt    = '0;
                end else begin
                    cnt_nxt = cnt + CNT_W'(1);
                end
            end
            default: begin
                state_nxt = DB_STABLE;
                cnt_nxt   = '0;
            end
        endcase
    end

    assign o_stable = stable;

endmodule

// File: rtl/sw_debounce.sv
// Debounced slide-switch word for the LSU: one debounce lane per switch,
// zero-extended to the I/O word, plus a registered any-bit-changed pulse.
module sw_debounce
    import io_pkg::*;
#(
    parameter int N_SW       = SW_WIDTH,
    parameter int DEB_CYCLES = DEB_CYCLES_DEF
) (
    input  logic                 i_clk,
    input  logic                 i_reset_n,
    input  logic [N_SW-1:0]      i_sw_raw,
    output logic [IO_WORD_W-1:0] o_io_sw,
    output logic                 o_sw_chg
);

    logic [N_SW-1:0] stable;
    logic [N_SW-1:0] accept;

    for (genvar g = 0; g < N_SW; g++) begin : g_bit
        sw_debounce_bit #(
            .DEB_CYCLES (DEB_CYCLES)
        ) u_bit (
            .i_clk     (i_clk),
            .i_reset_n (i_reset_n),
            .i_raw     (i_sw_raw[g]),
            .o_stable  (stable[g]),
            .o_accept  (accept[g])
        );
    end

    always_comb begin
        o_io_sw            = '0;
        o_io_sw[N_SW-1:0]  = stable;
    end

    // Registered on the same edge that updates stable, so the pulse lines up with the new word.
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            o_sw_chg <= 1'b0;
        end else begin
            o_sw_chg <= |accept;
        end
    end

endmodule
